// File: rtl/chip_test_pkg.sv
// Shared types and default constants for the chip-tester result display sequencer.
package chip_test_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT_DONE,
        S_SETTLE,
        S_SHOW,
        S_RELEASE
    } disp_state_t;

    localparam int unsigned DISP_HOLD_CYCLES_DEF = 50_000_000;
    localparam int unsigned DISP_TIMEOUT_DEF     = 1024;

endpackage

// File: rtl/cycle_timer.sv
// Up-counter with synchronous clear and a terminal-count flag at a run-time limit.
module cycle_timer #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         enable,
    input  logic [W-1:0] limit,
    output logic         terminal
);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    assign terminal = (count == limit);

endmodule

// File: rtl/result_display_ctrl.sv
// Launches a chip test, latches and displays its result, keeps saturating tallies.
// Optional WAIT_DONE timeout is compiled in with RESULT_DISPLAY_TIMEOUT_EN.
module result_display_ctrl
    import chip_test_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES    = DISP_HOLD_CYCLES_DEF,
    parameter int unsigned TIMEOUT_CYCLES = DISP_TIMEOUT_DEF,
    parameter int unsigned CNT_W          = 8
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             Start,
    input  logic             Done,
    input  logic             RSLT,
    output logic             Run,
    output logic             DISP_RSLT,
    output logic             Busy,
    output logic             LED_Pass,
    output logic             LED_Fail,
    output logic             Timeout_Flag,
    output logic [CNT_W-1:0] Pass_Count,
    output logic [CNT_W-1:0] Fail_Count
);

    // One timer serves both phases, so it is sized for the longer of the two.
    localparam int unsigned TMR_MAX = (HOLD_CYCLES > TIMEOUT_CYCLES) ? HOLD_CYCLES : TIMEOUT_CYCLES;
    localparam int unsigned TMR_W   = $clog2(TMR_MAX);
    localparam logic [TMR_W-1:0] HOLD_LIM = TMR_W'(HOLD_CYCLES - 1);
`ifdef RESULT_DISPLAY_TIMEOUT_EN
    localparam logic [TMR_W-1:0] TO_LIM = TMR_W'(TIMEOUT_CYCLES - 1);
`endif

    disp_state_t      state, next_state;
    logic             start_prev;
    logic             start_rise;
    logic             tmr_clear;
    logic             tmr_en;
    logic             tmr_tc;
    logic [TMR_W-1:0] tmr_limit;
    logic             led_pass;
    logic             led_fail;
    logic [CNT_W-1:0] pass_cnt;
    logic [CNT_W-1:0] fail_cnt;

    assign start_rise = Start & ~start_prev;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state      <= S_IDLE;
            start_prev <= 1'b0;
        end else begin
            state      <= next_state;
            start_prev <= Start;
        end
    end

    always_comb begin
        next_state = state;
        tmr_clear  = 1'b0;
        tmr_en     = 1'b0;
        tmr_limit  = HOLD_LIM;
        case (state)
            S_IDLE: begin
                if (start_rise) next_state = S_LAUNCH;
            end
            S_LAUNCH: begin
                tmr_clear  = 1'b1;
                next_state = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
`ifdef RESULT_DISPLAY_TIMEOUT_EN
                tmr_en    = 1'b1;
                tmr_limit = TO_LIM;
`endif
                if (Done) begin
                    next_state = S_SETTLE;
                end
`ifdef RESULT_DISPLAY_TIMEOUT_EN
                else if (tmr_tc) begin
                    next_state = S_SHOW;
                    tmr_clear  = 1'b1;
                end
`endif
            end
            S_SETTLE: begin
                tmr_clear  = 1'b1;
                next_state = S_SHOW;
            end
            S_SHOW: begin
                tmr_en = 1'b1;
                if (tmr_tc) next_state = S_RELEASE;
            end
            S_RELEASE: begin
                next_state = S_IDLE;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    cycle_timer #(.W(TMR_W)) u_timer (
        .clk      (Clk),
        .rst_n    (Reset_n),
        .clear    (tmr_clear),
        .enable   (tmr_en),
        .limit    (tmr_limit),
        .terminal (tmr_tc)
    );

`ifdef RESULT_DISPLAY_TIMEOUT_EN
    logic timeout_flag;
    logic timeout_hit;

    // Done has priority over a coincident terminal count.
    assign timeout_hit = (state == S_WAIT_DONE) && !Done && tmr_tc;
`endif

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            led_pass <= 1'b0;
            led_fail <= 1'b0;
            pass_cnt <= '0;
            fail_cnt <= '0;
`ifdef RESULT_DISPLAY_TIMEOUT_EN
            timeout_flag <= 1'b0;
`endif
        end else begin
            if (state == S_LAUNCH) begin
                led_pass <= 1'b0;
                led_fail <= 1'b0;
`ifdef RESULT_DISPLAY_TIMEOUT_EN
                timeout_flag <= 1'b0;
`endif
            end
`ifdef RESULT_DISPLAY_TIMEOUT_EN
            if (timeout_hit) begin
                timeout_flag <= 1'b1;
                led_fail     <= 1'b1;
                if (fail_cnt != '1) fail_cnt <= fail_cnt + 1'b1;
            end
`endif
            if (state == S_SETTLE) begin
                if (RSLT) begin
                    led_pass <= 1'b1;
                    if (pass_cnt != '1) pass_cnt <= pass_cnt + 1'b1;
                end else begin
                    led_fail <= 1'b1;
                    if (fail_cnt != '1) fail_cnt <= fail_cnt + 1'b1;
                end
            end
        end
    end

`ifdef RESULT_DISPLAY_TIMEOUT_EN
    assign Timeout_Flag = timeout_flag;
`else
    assign Timeout_Flag = 1'b0;
`endif

    assign Run        = (state == S_LAUNCH);
    assign DISP_RSLT  = (state == S_RELEASE);
    assign Busy       = (state != S_IDLE);
    assign LED_Pass   = led_pass;
    assign LED_Fail   = led_fail;
    assign Pass_Count = pass_cnt;
    assign Fail_Count = fail_cnt;

endmodule

// File: tb/tb_result_display_ctrl.sv
// Self-checking bench for result_display_ctrl; honours RESULT_DISPLAY_TIMEOUT_EN if defined.
module tb_result_display_ctrl;

    localparam int HOLD = 4;
    localparam int TO   = 16;
    localparam int CW   = 2;
    localparam int CMAX = (1 << CW) - 1;
`ifdef RESULT_DISPLAY_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic          Clk = 1'b0;
    logic          Reset_n;
    logic          Start;
    logic          Done;
    logic          RSLT;
    logic          Run;
    logic          DISP_RSLT;
    logic          Busy;
    logic          LED_Pass;
    logic          LED_Fail;
    logic          Timeout_Flag;
    logic [CW-1:0] Pass_Count;
    logic [CW-1:0] Fail_Count;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: tallies and the latched result left by the previous run.
    int exp_pass_cnt = 0;
    int exp_fail_cnt = 0;
    bit prev_lp = 1'b0;
    bit prev_lf = 1'b0;
    bit prev_to = 1'b0;

    typedef struct {
        int d;      // cycles from Run to Done rising; 0 = never
        bit r1;     // RSLT during Done's first cycle
        bit r2;     // RSLT from the next cycle on
        bit hold;   // keep Start high through the whole run
        bit lp;
        bit lf;
        bit to;
    } vec_t;

    vec_t tbl[$];

    always #5 Clk = ~Clk;

    result_display_ctrl #(
        .HOLD_CYCLES    (HOLD),
        .TIMEOUT_CYCLES (TO),
        .CNT_W          (CW)
    ) dut (
        .Clk          (Clk),
        .Reset_n      (Reset_n),
        .Start        (Start),
        .Done         (Done),
        .RSLT         (RSLT),
        .Run          (Run),
        .DISP_RSLT    (DISP_RSLT),
        .Busy         (Busy),
        .LED_Pass     (LED_Pass),
        .LED_Fail     (LED_Fail),
        .Timeout_Flag (Timeout_Flag),
        .Pass_Count   (Pass_Count),
        .Fail_Count   (Fail_Count)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    function automatic int sat(input int v);
        return (v >= CMAX) ? CMAX : v + 1;
    endfunction

    // A run either times out (no Done within TO waiting cycles) or reports RSLT one cycle after Done.
    task automatic predict(input int d, input bit r2, output bit lp, output bit lf, output bit to);
        to = TO_EN && (d == 0 || d > TO);
        lp = !to && r2;
        lf = !lp;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_run"},  int'(Run),          0);
        chk({tag, "_disp"}, int'(DISP_RSLT),    0);
        chk({tag, "_busy"}, int'(Busy),         0);
        chk({tag, "_lp"},   int'(LED_Pass),     0);
        chk({tag, "_lf"},   int'(LED_Fail),     0);
        chk({tag, "_to"},   int'(Timeout_Flag), 0);
        chk({tag, "_pc"},   int'(Pass_Count),   0);
        chk({tag, "_fc"},   int'(Fail_Count),   0);
    endtask

    // Cycle 0 is the LAUNCH cycle; expectations are derived from the run timeline.
    task automatic run_test(input vec_t v);
        int show0;
        int rel;
        int old_pc;
        int old_fc;
        int new_pc;
        int new_fc;
        show0  = v.to ? TO + 1 : v.d + 2;
        rel    = show0 + HOLD;
        old_pc = exp_pass_cnt;
        old_fc = exp_fail_cnt;
        new_pc = v.lp ? sat(old_pc) : old_pc;
        new_fc = v.lf ? sat(old_fc) : old_fc;
        Start  = 1'b1;
        tick();
        for (int i = 0; i <= rel + 1; i++) begin
            chk("run",  int'(Run),       (i == 0) ? 1 : 0);
            chk("disp", int'(DISP_RSLT), (i == rel) ? 1 : 0);
            chk("busy", int'(Busy),      (i <= rel) ? 1 : 0);
            if (i == 0) begin
                chk("lp_keep", int'(LED_Pass),     int'(prev_lp));
                chk("lf_keep", int'(LED_Fail),     int'(prev_lf));
                chk("to_keep", int'(Timeout_Flag), int'(prev_to));
            end else if (i < show0) begin
                chk("lp_clr", int'(LED_Pass),     0);
                chk("lf_clr", int'(LED_Fail),     0);
                chk("to_clr", int'(Timeout_Flag), 0);
            end else begin
                chk("lp", int'(LED_Pass),     int'(v.lp));
                chk("lf", int'(LED_Fail),     int'(v.lf));
                chk("to", int'(Timeout_Flag), int'(v.to));
            end
            chk("pcnt", int'(Pass_Count), (i < show0) ? old_pc : new_pc);
            chk("fcnt", int'(Fail_Count), (i < show0) ? old_fc : new_fc);
            Done = (v.d > 0) && (i >= v.d) && (i <= rel);
            if (v.d > 0 && i == v.d)     RSLT = v.r1;
            else if (v.d > 0 && i > v.d) RSLT = v.r2;
            else                         RSLT = 1'($urandom_range(0, 1));
            if (!v.hold) Start = 1'b0;
            tick();
        end
        Done = 1'b0;
        exp_pass_cnt = new_pc;
        exp_fail_cnt = new_fc;
        prev_lp = v.lp;
        prev_lf = v.lf;
        prev_to = v.to;
        if (v.hold) begin
            for (int k = 0; k < 3; k++) begin
                chk("held_run",  int'(Run),  0);
                chk("held_busy", int'(Busy), 0);
                tick();
            end
            Start = 1'b0;
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        Reset_n = 1'b0;
        Start   = 1'b0;
        Done    = 1'b0;
        RSLT    = 1'b0;

        tbl.push_back(vec_t'{10, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0});  // pass path
        tbl.push_back(vec_t'{5,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});  // RSLT settles to fail
        tbl.push_back(vec_t'{0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1});  // no Done: timeout
        tbl.push_back(vec_t'{16, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0});  // Done on terminal count wins
        tbl.push_back(vec_t'{17, 1'b0, 1'b1, 1'b0, !TO_EN, TO_EN, TO_EN}); // late Done
        tbl.push_back(vec_t'{1,  1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0});
        tbl.push_back(vec_t'{3,  1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0});  // Start held high
        tbl.push_back(vec_t'{7,  1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0});
        tbl.push_back(vec_t'{2,  1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0});
        tbl.push_back(vec_t'{4,  1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0});

        #12;
        check_all_zero("reset");
        Reset_n = 1'b1;
        tick();
        chk("idle_busy", int'(Busy), 0);

        foreach (tbl[n]) begin
            if (tbl[n].d != 0 || TO_EN) run_test(tbl[n]);
        end
        chk("pass_saturated", int'(Pass_Count), CMAX);

`ifndef RESULT_DISPLAY_TIMEOUT_EN
        // Without the timeout, WAIT_DONE must hold indefinitely.
        Start = 1'b1;
        tick();
        chk("nto_run", int'(Run), 1);
        Start = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            chk("nto_busy", int'(Busy),         1);
            chk("nto_disp", int'(DISP_RSLT),    0);
            chk("nto_to",   int'(Timeout_Flag), 0);
        end
        Done = 1'b1;
        RSLT = 1'b0;
        tick();
        tick();
        exp_fail_cnt = sat(exp_fail_cnt);
        chk("nto_lf", int'(LED_Fail),   1);
        chk("nto_fc", int'(Fail_Count), exp_fail_cnt);
        for (int i = 0; i < HOLD; i++) tick();
        chk("nto_disp_pulse", int'(DISP_RSLT), 1);
        Done = 1'b0;
        tick();
        chk("nto_idle", int'(Busy), 0);
        prev_lp = 1'b0;
        prev_lf = 1'b1;
        prev_to = 1'b0;
`endif

        for (int n = 0; n < 20; n++) begin
            v.d    = $urandom_range(1, 20);
            v.r1   = 1'($urandom_range(0, 1));
            v.r2   = 1'($urandom_range(0, 1));
            v.hold = 1'($urandom_range(0, 1));
            predict(v.d, v.r2, v.lp, v.lf, v.to);
            run_test(v);
        end

        // Reset in the middle of SHOW.
        Start = 1'b1;
        tick();
        Start = 1'b0;
        Done  = 1'b1;
        RSLT  = 1'b1;
        tick();
        tick();
        tick();
        chk("mid_busy", int'(Busy), 1);
        #2;
        Reset_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        Done = 1'b0;
        tick();
        Reset_n = 1'b1;
        tick();
        chk("post_reset_busy", int'(Busy), 0);
        exp_pass_cnt = 0;
        exp_fail_cnt = 0;
        prev_lp = 1'b0;
        prev_lf = 1'b0;
        prev_to = 1'b0;
        run_test(vec_t'{4, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
